// File: rtl/snn_train_sequencer.sv
// Purpose : schedules image presentation, rest gaps, teacher labels and STDP gating
//           for the spiking digit network; loops images for a number of epochs.
// Latency : every output is registered and moves one CLK after its cause (EN_NEURON tick,
//           START, ABORT); RST clears everything asynchronously.
// Flow    : no backpressure; progress is paced purely by EN_NEURON, which freezes the
//           sequencer (outputs held) while low.
// Ports   : CLK, RST (async active-low), START, ABORT, MODE (1=train), EN_NEURON in;
//           IMAGE/LABEL one-hot selects, TRAIN_EN, BUSY, DONE pulse, IMG_IDX, EPOCH_CNT out.
module snn_train_sequencer #(
  parameter int NUM_IMAGES = 10,
  parameter int LABEL_W    = 6,
  parameter int IDX_W      = 3,
  parameter logic [NUM_IMAGES*IDX_W-1:0] LABEL_MAP = 30'h1A22C688,
  parameter int WINDOW      = 150,
  parameter int PRESENT_WIN = 4,
  parameter int REST_WIN    = 1,
  parameter int EPOCHS      = 8,
  localparam int IMG_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic                  MODE,
  input  logic                  EN_NEURON,
  output logic [NUM_IMAGES-1:0] IMAGE,
  output logic [LABEL_W-1:0]    LABEL,
  output logic                  TRAIN_EN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [IMG_W-1:0]      IMG_IDX,
  output logic [7:0]            EPOCH_CNT
);

  localparam int TICK_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WIN_MAX = (PRESENT_WIN > REST_WIN) ? PRESENT_WIN : REST_WIN;
  localparam int WIN_W   = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0]  PRES_LAST = WIN_W'(PRESENT_WIN - 1);
  // Only meaningful when REST_WIN >= 1; with REST_WIN == 0 the REST state is never entered.
  localparam logic [WIN_W-1:0]  REST_LAST = WIN_W'(REST_WIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_REST, S_DONE} state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic                run_mode;

  logic                last_img;
  logic                tick_last;
  logic                win_last;
  logic                run_over;
  logic [IMG_W-1:0]    nxt_idx;
  logic [7:0]          epoch_inc;

  function automatic logic [NUM_IMAGES-1:0] img_onehot(input logic [IMG_W-1:0] idx);
    logic [NUM_IMAGES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_IMAGES; i++) oh[i] = (idx == IMG_W'(i));
    return oh;
  endfunction

  // Label indices that fall outside the neuron range decode to all-zero.
  function automatic logic [LABEL_W-1:0] label_onehot(input logic [IMG_W-1:0] idx);
    logic [IDX_W-1:0]   fld;
    logic [LABEL_W-1:0] oh;
    fld = '0;
    oh  = '0;
    for (int i = 0; i < NUM_IMAGES; i++)
      if (idx == IMG_W'(i)) fld = LABEL_MAP[i*IDX_W +: IDX_W];
    for (int j = 0; j < LABEL_W; j++) oh[j] = (fld == IDX_W'(j));
    return oh;
  endfunction

  always_comb begin
    last_img  = (IMG_IDX == IMG_W'(NUM_IMAGES - 1));
    nxt_idx   = last_img ? '0 : IMG_IDX + IMG_W'(1);
    epoch_inc = (EPOCH_CNT == 8'hFF) ? 8'hFF : EPOCH_CNT + 8'd1;
    // Inference runs are a single pass regardless of EPOCHS.
    run_over  = last_img && (int'(epoch_inc) == (run_mode ? EPOCHS : 1));
    tick_last = (tick_cnt == TICK_LAST);
    win_last  = (state == S_PRESENT) ? (win_cnt == PRES_LAST) : (win_cnt == REST_LAST);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      win_cnt   <= '0;
      run_mode  <= 1'b0;
      IMAGE     <= '0;
      LABEL     <= '0;
      TRAIN_EN  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      IMG_IDX   <= '0;
      EPOCH_CNT <= '0;
    end else if (ABORT && state != S_IDLE) begin
      // Abort leaves the counters where they were; only the visible outputs drop.
      state    <= S_IDLE;
      IMAGE    <= '0;
      LABEL    <= '0;
      TRAIN_EN <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START && !ABORT) begin
            state     <= S_PRESENT;
            run_mode  <= MODE;
            IMG_IDX   <= '0;
            EPOCH_CNT <= '0;
            tick_cnt  <= '0;
            win_cnt   <= '0;
            IMAGE     <= img_onehot('0);
            LABEL     <= MODE ? label_onehot('0) : '0;
            TRAIN_EN  <= MODE;
            BUSY      <= 1'b1;
          end
        end

        S_PRESENT, S_REST: begin
          if (EN_NEURON) begin
            if (!tick_last) begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end else begin
              tick_cnt <= '0;
              if (!win_last) begin
                win_cnt <= win_cnt + WIN_W'(1);
              end else begin
                win_cnt <= '0;
                if (state == S_PRESENT && REST_WIN != 0) begin
                  state <= S_REST;
                  IMAGE <= '0;
                  LABEL <= '0;
                end else begin
                  // Next-image step, taken on the same tick that closes the window.
                  IMG_IDX <= nxt_idx;
                  if (last_img) EPOCH_CNT <= epoch_inc;
                  if (run_over) begin
                    state    <= S_DONE;
                    IMAGE    <= '0;
                    LABEL    <= '0;
                    TRAIN_EN <= 1'b0;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b1;
                  end else begin
                    state <= S_PRESENT;
                    IMAGE <= img_onehot(nxt_idx);
                    LABEL <= run_mode ? label_onehot(nxt_idx) : '0;
                  end
                end
              end
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          DONE  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
